// File: rtl/fetch_pc_tracker.sv
// Fetch PC generator plus in-order prediction tracker: records {pc, predicted next pc} per fetch,
// checks each against execute's resolution, and on mismatch flushes, redirects and trains the BTB.
`ifndef PC_SIZE
`define PC_SIZE 32
`endif

module fetch_pc_tracker #(
    parameter int              PC_W     = `PC_SIZE,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            stall,
    input  logic            btb_hit,
    input  logic [PC_W-1:0] btb_target,
    output logic [PC_W-1:0] fetch_pc,
    output logic            fetch_valid,
    input  logic            res_valid,
    input  logic            res_is_br,
    input  logic [PC_W-1:0] res_next_pc,
    output logic            flush,
    output logic            fb_valid,
    output logic [PC_W-1:0] fb_pc,
    output logic [PC_W-1:0] fb_target,
    output logic            full,
    output logic            err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [PC_W-1:0] pc_mem   [DEPTH];
    logic [PC_W-1:0] pred_mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     count;

    logic [PC_W-1:0] pred_next;
    logic [PC_W-1:0] head_pc;
    logic [PC_W-1:0] head_pred;
    logic            not_empty;
    logic            pop;
    logic            mis;
    logic            push;

    assign pred_next = btb_hit ? btb_target : fetch_pc + PC_W'(1);
    assign head_pc   = pc_mem[rd_ptr];
    assign head_pred = pred_mem[rd_ptr];
    assign not_empty = (count != '0);
    // Gating with n_rst keeps flush/fb/fetch_valid quiet during a reset cycle.
    assign pop       = n_rst & res_valid & not_empty;
    assign mis       = pop & (head_pred != res_next_pc);
    assign push      = n_rst & ~stall & ~mis & ((count < DEPTH_C) | pop);

    assign fetch_valid = push;
    assign flush       = mis;
    // A not-taken branch predicted taken resolves to pc+1, which needs no BTB entry.
    assign fb_valid    = mis & res_is_br & (res_next_pc != head_pc + PC_W'(1));
    assign fb_pc       = fb_valid ? head_pc : '0;
    assign fb_target   = fb_valid ? res_next_pc : '0;
    assign full        = (count == DEPTH_C);

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= fetch_pc;
            pred_mem[wr_ptr] <= pred_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            err      <= 1'b0;
        end else begin
            if (res_valid && !not_empty)
                err <= 1'b1;
            if (mis) begin
                fetch_pc <= res_next_pc;
                count    <= '0;
                rd_ptr   <= wr_ptr;
            end else begin
                if (push) begin
                    fetch_pc <= pred_next;
                    wr_ptr   <= wr_ptr + AW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + (AW+1)'(1);
                    2'b01:   count <= count - (AW+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_pc_tracker.sv
// Directed testbench for fetch_pc_tracker with PC_W=8, RESET_PC=0x10, DEPTH=4.
module tb_fetch_pc_tracker;
    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       stall = 1'b0;
    logic       btb_hit = 1'b0;
    logic [7:0] btb_target = '0;
    logic [7:0] fetch_pc;
    logic       fetch_valid;
    logic       res_valid = 1'b0;
    logic       res_is_br = 1'b0;
    logic [7:0] res_next_pc = '0;
    logic       flush;
    logic       fb_valid;
    logic [7:0] fb_pc;
    logic [7:0] fb_target;
    logic       full;
    logic       err;

    int passed = 0;
    int total = 0;
    logic [7:0] exp_pc;

    fetch_pc_tracker #(.PC_W(8), .RESET_PC(8'h10), .DEPTH(4)) dut (
        .clk(clk), .n_rst(n_rst), .stall(stall), .btb_hit(btb_hit), .btb_target(btb_target),
        .fetch_pc(fetch_pc), .fetch_valid(fetch_valid), .res_valid(res_valid),
        .res_is_br(res_is_br), .res_next_pc(res_next_pc), .flush(flush), .fb_valid(fb_valid),
        .fb_pc(fb_pc), .fb_target(fb_target), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_rst = 1'b0; stall = 1'b0; btb_hit = 1'b0; btb_target = '0;
        res_valid = 1'b0; res_is_br = 1'b0; res_next_pc = '0;
        tick();
        tick();
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        tick();
        tick();
        #1;
        total++; if (fetch_pc !== 8'h10) $display("FAIL rst_pc got %h want 10", fetch_pc); else passed++;
        total++; if (fetch_valid !== 1'b0) $display("FAIL rst_fetch_valid got %b want 0", fetch_valid); else passed++;
        total++; if (err !== 1'b0 || full !== 1'b0 || flush !== 1'b0) $display("FAIL rst_flags got err=%b full=%b flush=%b want 0", err, full, flush); else passed++;
        n_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_pc = 8'h10 + 8'(i);
            total++; if (fetch_pc !== exp_pc || fetch_valid !== 1'b1) $display("FAIL seq_fetch got pc=%h v=%b want pc=%h v=1", fetch_pc, fetch_valid, exp_pc); else passed++;
            tick();
        end
        #1;
        total++; if (full !== 1'b1 || fetch_valid !== 1'b0) $display("FAIL full_block got full=%b v=%b want full=1 v=0", full, fetch_valid); else passed++;
        tick();
        total++; if (fetch_pc !== 8'h14) $display("FAIL full_hold got %h want 14", fetch_pc); else passed++;
    endtask

    task automatic test_btb_hit();
        do_reset();
        tick();
        tick();
        btb_hit = 1'b1; btb_target = 8'h40;
        #1;
        total++; if (fetch_pc !== 8'h12 || fetch_valid !== 1'b1) $display("FAIL hit_fetch got pc=%h v=%b want 12/1", fetch_pc, fetch_valid); else passed++;
        tick();
        btb_hit = 1'b0; stall = 1'b1;
        #1;
        total++; if (fetch_pc !== 8'h40) $display("FAIL hit_next_pc got %h want 40", fetch_pc); else passed++;
        total++; if (fetch_valid !== 1'b0) $display("FAIL stall_fetch_valid got %b want 0", fetch_valid); else passed++;
        res_valid = 1'b1; res_next_pc = 8'h11;
        #1;
        total++; if (flush !== 1'b0) $display("FAIL hit_res0_flush got %b want 0", flush); else passed++;
        tick();
        res_next_pc = 8'h12;
        #1;
        total++; if (flush !== 1'b0) $display("FAIL hit_res1_flush got %b want 0", flush); else passed++;
        tick();
        res_next_pc = 8'h40; res_is_br = 1'b1;
        #1;
        total++; if (flush !== 1'b0 || fb_valid !== 1'b0 || fb_pc !== 8'h00) $display("FAIL hit_res2 got flush=%b fbv=%b fbpc=%h want 0/0/00", flush, fb_valid, fb_pc); else passed++;
        tick();
        res_valid = 1'b0; res_is_br = 1'b0;
        #1;
        total++; if (fetch_pc !== 8'h40 || err !== 1'b0) $display("FAIL hit_after got pc=%h err=%b want 40/0", fetch_pc, err); else passed++;
    endtask

    task automatic test_mispredict_taken();
        do_reset();
        btb_hit = 1'b1; btb_target = 8'h20;
        tick();
        btb_hit = 1'b0;
        tick();
        stall = 1'b1;
        res_valid = 1'b1; res_next_pc = 8'h20;
        tick();
        stall = 1'b0; res_is_br = 1'b1; res_next_pc = 8'h80;
        #1;
        total++; if (flush !== 1'b1 || fb_valid !== 1'b1) $display("FAIL mt_flags got flush=%b fbv=%b want 1/1", flush, fb_valid); else passed++;
        total++; if (fb_pc !== 8'h20 || fb_target !== 8'h80) $display("FAIL mt_fb got pc=%h tgt=%h want 20/80", fb_pc, fb_target); else passed++;
        total++; if (fetch_valid !== 1'b0) $display("FAIL mt_no_push got %b want 0", fetch_valid); else passed++;
        tick();
        res_valid = 1'b0; res_is_br = 1'b0;
        #1;
        total++; if (fetch_pc !== 8'h80 || full !== 1'b0 || flush !== 1'b0) $display("FAIL mt_redirect got pc=%h full=%b flush=%b want 80/0/0", fetch_pc, full, flush); else passed++;
        tick(); tick(); tick(); tick();
        total++; if (fetch_pc !== 8'h84 || full !== 1'b1) $display("FAIL mt_cleared got pc=%h full=%b want 84/1", fetch_pc, full); else passed++;
    endtask

    task automatic test_mispredict_not_taken();
        do_reset();
        btb_hit = 1'b1; btb_target = 8'h30;
        tick();
        btb_target = 8'h50;
        tick();
        btb_hit = 1'b0; stall = 1'b1;
        res_valid = 1'b1; res_next_pc = 8'h30;
        tick();
        res_is_br = 1'b1; res_next_pc = 8'h31;
        #1;
        total++; if (flush !== 1'b1 || fb_valid !== 1'b0) $display("FAIL mnt_flags got flush=%b fbv=%b want 1/0", flush, fb_valid); else passed++;
        total++; if (fb_pc !== 8'h00 || fb_target !== 8'h00) $display("FAIL mnt_fb_zero got pc=%h tgt=%h want 00/00", fb_pc, fb_target); else passed++;
        tick();
        res_valid = 1'b0; res_is_br = 1'b0;
        #1;
        total++; if (fetch_pc !== 8'h31) $display("FAIL mnt_redirect_stalled got %h want 31", fetch_pc); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        tick(); tick(); tick(); tick();
        total++; if (full !== 1'b1 || fetch_pc !== 8'h14) $display("FAIL b2b_fill got full=%b pc=%h want 1/14", full, fetch_pc); else passed++;
        for (int i = 0; i < 10; i++) begin
            res_valid = 1'b1; res_next_pc = 8'h11 + 8'(i);
            exp_pc = 8'h14 + 8'(i);
            #1;
            total++; if (fetch_pc !== exp_pc || fetch_valid !== 1'b1 || full !== 1'b1 || flush !== 1'b0)
                $display("FAIL b2b_step%0d got pc=%h v=%b full=%b flush=%b want %h/1/1/0", i, fetch_pc, fetch_valid, full, flush, exp_pc);
            else passed++;
            tick();
        end
        res_valid = 1'b0;
        #1;
        total++; if (fetch_pc !== 8'h1e || full !== 1'b1 || fetch_valid !== 1'b0) $display("FAIL b2b_end got pc=%h full=%b v=%b want 1e/1/0", fetch_pc, full, fetch_valid); else passed++;
    endtask

    task automatic test_empty_err();
        do_reset();
        stall = 1'b1;
        res_valid = 1'b1; res_is_br = 1'b1; res_next_pc = 8'h99;
        #1;
        total++; if (flush !== 1'b0 || fb_valid !== 1'b0) $display("FAIL empty_res got flush=%b fbv=%b want 0/0", flush, fb_valid); else passed++;
        tick();
        res_valid = 1'b0; res_is_br = 1'b0;
        tick();
        total++; if (err !== 1'b1 || fetch_pc !== 8'h10) $display("FAIL err_sticky got err=%b pc=%h want 1/10", err, fetch_pc); else passed++;
        stall = 1'b0;
        tick(); tick();
        n_rst = 1'b0; res_valid = 1'b1; res_next_pc = 8'h77; res_is_br = 1'b1;
        #1;
        total++; if (flush !== 1'b0 || fb_valid !== 1'b0 || fetch_valid !== 1'b0) $display("FAIL rst_mid got flush=%b fbv=%b v=%b want 0/0/0", flush, fb_valid, fetch_valid); else passed++;
        tick();
        n_rst = 1'b1; res_valid = 1'b0; res_is_br = 1'b0;
        #1;
        total++; if (err !== 1'b0 || fetch_pc !== 8'h10 || full !== 1'b0) $display("FAIL rst_clear got err=%b pc=%h full=%b want 0/10/0", err, fetch_pc, full); else passed++;
    endtask

    initial begin
        test_reset();
        test_btb_hit();
        test_mispredict_taken();
        test_mispredict_not_taken();
        test_back_to_back();
        test_empty_err();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
